// File: rtl/sonar_pkg.sv
// sonar_pkg: state codes and shared constants for the sonar sweep sequencer.
package sonar_pkg;
  localparam int DIST_W_PADRAO = 12;
  localparam logic [DIST_W_PADRAO-1:0] DIST_SATURADA = '1;
  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    POSICIONA     = 4'd1,
    MEDE          = 4'd2,
    ESPERA_MEDIDA = 4'd3,
    TRANSMITE     = 4'd4,
    ESPERA_TX     = 4'd5,
    AVANCA        = 4'd6
  } estado_t;
endpackage

// File: rtl/sonar_varredura_contador.sv
// contador_m: synchronous up-counter with clear, saturating at all ones, flagging a runtime limit.
module contador_m #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] limite_i,
  output logic         fim_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr_i ? '0 : (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign fim_o = cnt_q == limite_i;
endmodule

// File: rtl/sonar_varredura.sv
// sonar_varredura: servo sweep / trena measure / serial TX sequencer.
// Define SONAR_PINGPONG_EN for a back-and-forth sweep instead of the sawtooth.
module sonar_varredura
  import sonar_pkg::*;
#(
  parameter int N_POS          = 8,
  parameter int POS_W          = $clog2(N_POS),
  parameter int DIST_W         = DIST_W_PADRAO,
  parameter int SETTLE_CYCLES  = 10_000_000,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ligar,
  input  logic              medida_pronto,
  input  logic [DIST_W-1:0] medida,
  input  logic              tx_pronto,
  output logic [POS_W-1:0]  posicao,
  output logic              mensurar,
  output logic              tx_partida,
  output logic [POS_W-1:0]  tx_angulo,
  output logic [DIST_W-1:0] tx_distancia,
  output logic              timeout_err,
  output logic              fim_varredura,
  output logic [3:0]        db_estado
);
  localparam int MAX_C = SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W = MAX_C > 1 ? $clog2(MAX_C) : 1;
  estado_t state_q, state_d;
  logic [POS_W-1:0] posicao_q, posicao_d, tx_angulo_q, tx_angulo_d, prox;
  logic [DIST_W-1:0] tx_dist_q, tx_dist_d;
  logic mens_q, mens_d, part_q, part_d, terr_q, terr_d, fim_q, fim_d;
  logic cnt_fim, extremo;
  // one counter serves both the settle wait and the echo timeout
  contador_m #(.W(CNT_W)) u_contador (
    .clk      (clock),
    .rst      (reset),
    .clr_i    (state_q inside {IDLE, MEDE, AVANCA}),
    .en_i     (state_q inside {POSICIONA, ESPERA_MEDIDA}),
    .limite_i (state_q == POSICIONA ? CNT_W'(SETTLE_CYCLES - 1) : CNT_W'(TIMEOUT_CYCLES - 1)),
    .fim_o    (cnt_fim)
  );
`ifdef SONAR_PINGPONG_EN
  logic sobe_q, sobe_d;
  assign prox = sobe_q ? posicao_q + POS_W'(1) : posicao_q - POS_W'(1);
  assign extremo = prox == POS_W'(N_POS - 1) || prox == '0;
  assign sobe_d = (state_q == AVANCA && extremo) ? ~sobe_q : sobe_q;
  always_ff @(posedge clock) sobe_q <= reset ? 1'b1 : sobe_d;
`else
  assign extremo = posicao_q == POS_W'(N_POS - 1);
  assign prox = extremo ? '0 : posicao_q + POS_W'(1);
`endif
  always_comb begin
    state_d = state_q;
    posicao_d = posicao_q;
    tx_angulo_d = tx_angulo_q;
    tx_dist_d = tx_dist_q;
    mens_d = 1'b0;
    part_d = 1'b0;
    terr_d = 1'b0;
    fim_d = 1'b0;
    case (state_q)
      IDLE: state_d = ligar ? POSICIONA : IDLE;
      POSICIONA: state_d = cnt_fim ? MEDE : POSICIONA;
      MEDE: begin
        mens_d = 1'b1;
        state_d = ESPERA_MEDIDA;
      end
      ESPERA_MEDIDA: begin
        // an answer on the last timeout cycle still counts as a valid echo
        if (medida_pronto || cnt_fim) begin
          tx_angulo_d = posicao_q;
          tx_dist_d = medida_pronto ? medida : '1;
          terr_d = !medida_pronto;
          state_d = TRANSMITE;
        end
      end
      TRANSMITE: begin
        part_d = 1'b1;
        state_d = ESPERA_TX;
      end
      ESPERA_TX: state_d = tx_pronto ? AVANCA : ESPERA_TX;
      AVANCA: begin
        posicao_d = prox;
        fim_d = extremo;
        state_d = ligar ? POSICIONA : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      posicao_q <= '0;
      tx_angulo_q <= '0;
      tx_dist_q <= '0;
      mens_q <= 1'b0;
      part_q <= 1'b0;
      terr_q <= 1'b0;
      fim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      posicao_q <= posicao_d;
      tx_angulo_q <= tx_angulo_d;
      tx_dist_q <= tx_dist_d;
      mens_q <= mens_d;
      part_q <= part_d;
      terr_q <= terr_d;
      fim_q <= fim_d;
    end
  end
  assign posicao = posicao_q;
  assign mensurar = mens_q;
  assign tx_partida = part_q;
  assign tx_angulo = tx_angulo_q;
  assign tx_distancia = tx_dist_q;
  assign timeout_err = terr_q;
  assign fim_varredura = fim_q;
  assign db_estado = state_q;
endmodule

// File: tb/tb_sonar_varredura.sv
// tb_sonar_varredura: randomized trena/TX responders checked against an index-sequence model.
module tb_sonar_varredura;
  localparam int N = 4, S = 5, T = 20;
  logic clock = 1'b0, reset = 1'b1, ligar = 1'b0, medida_pronto = 1'b0, tx_pronto = 1'b0;
  logic [11:0] medida = '0, tx_distancia;
  logic [1:0] posicao, tx_angulo;
  logic mensurar, tx_partida, timeout_err, fim_varredura;
  logic [3:0] db_estado;
  int n_chk = 0, n_err = 0, cyc = 0, entrada = 0, passo = 0;
  int n_mens = 0, n_part = 0, n_terr = 0, n_fim = 0, c_terr = 0;
  always #5 clock = ~clock;
  sonar_varredura #(.N_POS(N), .DIST_W(12), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .ligar(ligar), .medida_pronto(medida_pronto),
    .medida(medida), .tx_pronto(tx_pronto), .posicao(posicao), .mensurar(mensurar),
    .tx_partida(tx_partida), .tx_angulo(tx_angulo), .tx_distancia(tx_distancia),
    .timeout_err(timeout_err), .fim_varredura(fim_varredura), .db_estado(db_estado)
  );
  task automatic verifica(input string tag, input int obs, input int esp);
    n_chk++;
    if (obs != esp) begin
      n_err++;
      $display("FAIL %s: obtido %0h esperado %0h (ciclo %0d)", tag, obs, esp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
    n_mens += int'(mensurar);
    n_part += int'(tx_partida);
    n_fim += int'(fim_varredura);
    if (timeout_err) begin
      n_terr++;
      c_terr = cyc;
    end
  endtask
  // index visited after k advances
  function automatic int indice(input int k);
    int r;
`ifdef SONAR_PINGPONG_EN
    r = k % (2 * N - 2);
    return r < N ? r : 2 * N - 2 - r;
`else
    r = k % N;
    return r;
`endif
  endfunction
  function automatic bit extremo_em(input int k);
`ifdef SONAR_PINGPONG_EN
    return indice(k) == 0 || indice(k) == N - 1;
`else
    return indice(k) == 0;
`endif
  endfunction
  task automatic verifica_reset();
    verifica("rst_estado", db_estado, 0);
    verifica("rst_pos", posicao, 0);
    verifica("rst_ang", tx_angulo, 0);
    verifica("rst_dist", tx_distancia, 0);
    verifica("rst_pulsos", {mensurar, tx_partida, timeout_err, fim_varredura}, 0);
  endtask
  // lat<0: trena never answers; solta: drop ligar mid-measurement; rst_tx: reset in ESPERA_TX
  task automatic transacao(input int lat, input int med, input int dtx, input bit solta, input bit rst_tx);
    int m, p, m0, p0, t0, f0, k;
    bit tout;
    while (cyc < entrada) tick();
    m0 = n_mens; p0 = n_part; t0 = n_terr; f0 = n_fim;
    k = 0;
    while (!mensurar && k < 40) begin
      medida_pronto = ($urandom_range(0, 3) == 0);
      medida = 12'($urandom);
      tick();
      k++;
    end
    verifica("t_mens", cyc - entrada, S + 1);
    verifica("pos", posicao, indice(passo));
    verifica("estado_med", db_estado, 3);
    m = cyc;
    tout = !(lat >= 0 && lat <= T - 1);
    k = 0;
    while (!tx_partida && k < 60) begin
      medida_pronto = (lat >= 0 && cyc - m == lat);
      medida = medida_pronto ? 12'(med) : 12'($urandom);
      tx_pronto = ($urandom_range(0, 3) == 0);
      if (solta && cyc - m == 1) ligar = 1'b0;
      tick();
      k++;
    end
    medida_pronto = 1'b0;
    tx_pronto = 1'b0;
    verifica("t_part", cyc - m, tout ? T + 1 : lat + 2);
    verifica("angulo", tx_angulo, indice(passo));
    verifica("dist", tx_distancia, tout ? 'hFFF : med);
    verifica("n_terr", n_terr - t0, int'(tout));
    if (tout) verifica("t_terr", c_terr - m, T);
    verifica("estado_tx", db_estado, 5);
    p = cyc;
    if (rst_tx) begin
      reset = 1'b1;
      tick();
      reset = 1'b0;
      verifica_reset();
      passo = 0;
      entrada = cyc + 1;
      return;
    end
    while (cyc < p + dtx + 2) begin
      tx_pronto = (cyc - p == dtx);
      medida_pronto = ($urandom_range(0, 3) == 0);
      tick();
    end
    tx_pronto = 1'b0;
    medida_pronto = 1'b0;
    verifica("fim", n_fim - f0, int'(extremo_em(passo + 1)));
    verifica("n_mens", n_mens - m0, 1);
    verifica("n_part", n_part - p0, 1);
    passo++;
    verifica("pos_nova", posicao, indice(passo));
    verifica("estado_fim", db_estado, ligar ? 1 : 0);
    entrada = cyc;
  endtask
  initial begin
    int lat;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    verifica_reset();
    repeat (3) tick();
    verifica("idle", db_estado, 0);
    ligar = 1'b1;
    entrada = cyc + 1;
    transacao(3, 'h123, 4, 1'b0, 1'b0);
    transacao(3, 'h123, 4, 1'b0, 1'b0);
    transacao(-1, 'h123, 4, 1'b0, 1'b0);
    transacao(3, 'h123, 4, 1'b0, 1'b0);
    transacao(T - 1, 'h456, 2, 1'b0, 1'b0);
    transacao(5, 'h789, 1, 1'b1, 1'b0);
    repeat (4) tick();
    verifica("pos_idle", posicao, indice(passo));
    verifica("idle2", db_estado, 0);
    ligar = 1'b1;
    entrada = cyc + 1;
    for (int i = 0; i < 12; i++) begin
      lat = int'($urandom_range(0, 25)) - 1;
      transacao(lat, int'($urandom_range(0, 4095)), int'($urandom_range(0, 6)), 1'b0, 1'b0);
    end
    transacao(4, 'hABC, 3, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      lat = int'($urandom_range(0, 25)) - 1;
      transacao(lat, int'($urandom_range(0, 4095)), int'($urandom_range(0, 6)), 1'b0, 1'b0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sonar_varredura.md
# sonar_varredura

Sweep sequencer for the sonar datapath. Steps the servo through `N_POS` angle positions, waits for mechanical settling, triggers one distance measurement per position and hands the (angle index, distance) pair to the serial transmitter. It sits between the trena measurement unit, the servo/angle ROM and the serial TX in the sonar top level, and replaces the fixed free-running wiring used so far.

## Interface
- `N_POS`, 8: number of sweep positions (≥2); also the angle-ROM depth.
- `POS_W`, `$clog2(N_POS)`: width of the position index.
- `DIST_W`, 12: width of the distance word (3 BCD digits).
- `SETTLE_CYCLES`, 10_000_000: servo settle wait per position (200 ms at 50 MHz).
- `TIMEOUT_CYCLES`, 2_500_000: maximum wait for `medida_pronto` (50 ms).

Ports:
- `clock` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `ligar` in 1: level; enables sweeping.
- `medida_pronto` in 1: one-cycle pulse from trena; measurement finished.
- `medida` in DIST_W: distance, valid when `medida_pronto`=1.
- `tx_pronto` in 1: one-cycle pulse from serial TX; pair sent.
- `posicao` out POS_W: current position index, driven to servo and angle ROM.
- `mensurar` out 1: one-cycle pulse; starts a trena measurement.
- `tx_partida` out 1: one-cycle pulse; starts transmission of `tx_angulo`/`tx_distancia`.
- `tx_angulo` out POS_W: latched index of the transmitted pair.
- `tx_distancia` out DIST_W: latched distance of the transmitted pair.
- `timeout_err` out 1: one-cycle pulse on a measurement timeout.
- `fim_varredura` out 1: one-cycle pulse when a sweep endpoint is reached.
- `db_estado` out 4: state code for debug displays.

## Operation
- States and `db_estado` codes: IDLE 0, POSICIONA 1, MEDE 2, ESPERA_MEDIDA 3, TRANSMITE 4, ESPERA_TX 5, AVANCA 6.
- IDLE: if `ligar`=1, go to POSICIONA and clear the counter.
- POSICIONA: count to `SETTLE_CYCLES`-1, then go to MEDE. The first position after IDLE also settles.
- MEDE: assert `mensurar` for this cycle only, clear the counter, go to ESPERA_MEDIDA.
- ESPERA_MEDIDA:
  - On `medida_pronto`: latch `tx_distancia`←`medida` and `tx_angulo`←`posicao`, then go to TRANSMITE.
  - If the counter reaches `TIMEOUT_CYCLES`-1 first: latch `tx_distancia`←all ones (saturated / no echo), pulse `timeout_err`, then go to TRANSMITE.
  - If `medida_pronto` and the timeout occur in the same cycle, `medida_pronto` wins and there is no `timeout_err`.
- TRANSMITE: assert `tx_partida` for this cycle only, go to ESPERA_TX.
- ESPERA_TX: wait for `tx_pronto` (no timeout), then go to AVANCA.
- AVANCA: compute the next index and update `posicao`. If `ligar`=0, go to IDLE; otherwise go to POSICIONA.
- `ligar` is only sampled in IDLE and AVANCA. A measure/transmit pair already in flight always completes.
- Sawtooth (default): index 0,1,…,N_POS-1,0,… At the wrap from N_POS-1 to 0, pulse `fim_varredura` in AVANCA.
- Pulses arriving outside their wait states are ignored. Examples: a stray `medida_pronto` in POSICIONA, or `tx_pronto` in ESPERA_MEDIDA.
- `posicao` holds its value in IDLE; a restart resumes from the held index.

## Timing
- Reset values:
  - state IDLE
  - `posicao`=0, `tx_angulo`=0, `tx_distancia`=0
  - `mensurar`, `tx_partida`, `timeout_err`, `fim_varredura` all 0
  - `db_estado`=0
  - direction = up
- Reset has priority at any point, including mid-measurement; the in-flight pair is discarded.
- All outputs are registered. Pulses are exactly one cycle wide.
- `ligar` rising edge in IDLE → POSICIONA on the next edge. `mensurar` rises `SETTLE_CYCLES`+1 cycles after POSICIONA is entered.
- `medida_pronto` at cycle t → `tx_partida`=1 at t+2; `tx_distancia` is stable from t+1.
- `tx_pronto` at cycle t → `posicao` updates at t+2, which is also the start of the next settle.
- Counter width is `$clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES))`. The counter is shared by the settle and timeout waits and never wraps.

## Configuration
- `SONAR_PINGPONG_EN` defined: back-and-forth sweep, 0,1,…,N_POS-1,N_POS-2,…,0,1,…
  - The direction register flips on reaching N_POS-1 and on reaching 0.
  - `fim_varredura` pulses in the AVANCA that lands on either endpoint.
  - With N_POS=2 the sequence is 0,1,0,1.
- Not defined: sawtooth only. The direction register is absent and `fim_varredura` pulses only on the wrap to 0.

## Structure
- Package `sonar_pkg`:
  - state enum `estado_t`, holding the `db_estado` codes
  - `DIST_W` default
  - `DIST_SATURADA` constant (all ones)
- One sub-module: `contador_m`, a parametrised synchronous counter with clear and end-of-count flag, instantiated once for the settle and timeout waits.
- Next-index logic and pair latching stay inline in the FSM.

## Test plan
- Config for all runs: N_POS=4, SETTLE_CYCLES=5, TIMEOUT_CYCLES=20.
- Sawtooth, `ligar`=1 held; trena model answers `medida`=12'h123 with `medida_pronto` 3 cycles after `mensurar`; TX model pulses `tx_pronto` 4 cycles after `tx_partida` → `tx_angulo` sequence 0,1,2,3,0. `fim_varredura` pulses once, in the AVANCA leaving index 3. `mensurar` comes 6 cycles after POSICIONA entry.
- Trena never answers at `posicao`=2 → `timeout_err` pulses 20 cycles after `mensurar`. Next `tx_partida` carries `tx_distancia`=12'hFFF and `tx_angulo`=2, and the sweep continues to 3.
- `medida_pronto` coincides with the last timeout cycle → `tx_distancia`=`medida`, no `timeout_err`.
- `ligar` dropped during ESPERA_MEDIDA at index 1 → the pair still transmits. FSM goes to IDLE with `posicao`=2. Raising `ligar` again resumes at 2.
- `reset` pulsed during ESPERA_TX → next cycle: state IDLE, `posicao`=0, all pulses 0, `tx_distancia`=0.
- `SONAR_PINGPONG_EN` → `tx_angulo` sequence 0,1,2,3,2,1,0,1. `fim_varredura` pulses at the arrivals at 3 and at 0.
